// File: rtl/mem_arbiter_pkg.sv
// Shared SoC constants: arbiter and monitor FSM encodings, common data width.
package mem_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } arb_state_t;

    typedef enum logic [1:0] {
        MonOff,
        MonArmed,
        MonTriggered
    } mon_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One client port of the memory arbiter: request/response handshake with byte data.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 18
);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single-ported RAM with 1-cycle read latency.
// Each access runs IDLE -> ACCESS -> DONE; ready pulses in DONE, read data lands one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic                  CLK,
    input  logic                  reset,
    mem_arbiter_if.slave          p0,
    mem_arbiter_if.slave          p1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  grant
);

    arb_state_t            state_q, state_d;
    logic                  last_q, last_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  winner;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        we_d     = we_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // Contention goes to the port not served last; a lone requester always wins.
        winner   = (p0.req && p1.req) ? ~last_q : p1.req;

        unique case (state_q)
            StIdle: begin
                we_d = 1'b0;
                if (p0.req || p1.req) begin
                    state_d = StAccess;
                    grant_d = winner;
                    last_d  = winner;
                    we_d    = winner ? p1.we    : p0.we;
                    is_wr_d = winner ? p1.we    : p0.we;
                    addr_d  = winner ? p1.addr  : p0.addr;
                    wdata_d = winner ? p1.wdata : p0.wdata;
                end
            end
            StAccess: begin
                state_d = StDone;
                we_d    = 1'b0;
                ready_d = grant_q ? 2'b10 : 2'b01;
            end
            StDone: begin
                state_d = StIdle;
                if (!is_wr_q) begin
                    if (grant_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Side-effecting strobes are masked by reset so an abandoned access neither writes nor completes.
    assign ram_we    = we_q & reset;
    assign p0.ready  = ready_q[0] & reset;
    assign p1.ready  = ready_q[1] & reset;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign grant     = grant_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

endmodule
